acumulador_suma: RTL and testbench

//  Sequential accumulator that sums a stream of N-bit unsigned operands.

---
 rtl/acumulador_suma.sv | 113 +++++++++++
 tb/tb_acumulador_suma.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/acumulador_suma.sv
// rtl/acumulador_suma.sv - sequential accumulator over a valid/ready operand stream
// Optional build macro: SATURACION_EN (saturate acc to all ones on adder carry-out).

module suma_parametrizable #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] suma,
  output logic         cout
);

  logic [N:0] total;

  always_comb begin
    total = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
  end

  assign suma = total[N-1:0];
  assign cout = total[N];

endmodule

module acumulador_suma #(
  parameter int N     = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inicio,
  input  logic [N-1:0]     dato,
  input  logic             dato_valid,
  output logic             dato_ready,
  input  logic             fin,
  output logic [N-1:0]     acc,
  output logic             cout_sticky,
  output logic [CNT_W-1:0] n_ops,
  output logic             zero,
  output logic             listo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACUM = 2'd1,
    DONE = 2'd2
  } estado_t;

  estado_t        estado;
  logic [N-1:0]   suma;
  logic           cout;
  logic [N-1:0]   acc_next;
  logic           lleno;
  logic           xfer;

  suma_parametrizable #(.N(N)) u_suma (
    .a    (acc),
    .b    (dato),
    .cin  (1'b0),
    .suma (suma),
    .cout (cout)
  );

  assign lleno      = (n_ops == {CNT_W{1'b1}});
  assign dato_ready = (estado == ACUM) && !inicio && !lleno;
  assign xfer       = dato_valid && dato_ready;
  assign zero       = (acc == '0);

`ifdef SATURACION_EN
  // Once at all ones, any nonzero operand carries out again, so the clamp holds itself.
  assign acc_next = cout ? {N{1'b1}} : suma;
`else
  assign acc_next = suma;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado      <= IDLE;
      acc         <= '0;
      n_ops       <= '0;
      cout_sticky <= 1'b0;
      listo       <= 1'b0;
    end else if (inicio) begin
      estado      <= ACUM;
      acc         <= '0;
      n_ops       <= '0;
      cout_sticky <= 1'b0;
      listo       <= 1'b0;
    end else begin
      case (estado)
        ACUM: begin
          // An operand arriving together with fin is still folded in.
          if (xfer) begin
            acc         <= acc_next;
            cout_sticky <= cout_sticky | cout;
            n_ops       <= n_ops + 1'b1;
          end
          if (fin) begin
            estado <= DONE;
            listo  <= 1'b1;
          end
        end
        DONE: begin
          listo <= 1'b1;
        end
        default: begin
          listo <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acumulador_suma.sv
// tb/tb_acumulador_suma.sv - directed self-checking bench for acumulador_suma

module tb_acumulador_suma;

  logic       clk = 1'b0;
  logic       rst;
  logic       inicio;
  logic [3:0] dato;
  logic       dato_valid;
  logic       dato_ready;
  logic       fin;
  logic [3:0] acc;
  logic       cout_sticky;
  logic [3:0] n_ops;
  logic       zero;
  logic       listo;

  int total = 0;
  int bad   = 0;

  acumulador_suma #(.N(4), .CNT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .inicio      (inicio),
    .dato        (dato),
    .dato_valid  (dato_valid),
    .dato_ready  (dato_ready),
    .fin         (fin),
    .acc         (acc),
    .cout_sticky (cout_sticky),
    .n_ops       (n_ops),
    .zero        (zero),
    .listo       (listo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; the next rising edge consumes them.
  task automatic step(input logic ini, input logic fn, input logic v, input logic [3:0] d);
    @(negedge clk);
    inicio     = ini;
    fin        = fn;
    dato_valid = v;
    dato       = d;
    #1;
  endtask

  initial begin
    rst = 1'b1; inicio = 1'b0; fin = 1'b0; dato_valid = 1'b0; dato = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_acc", acc, 0);
    check("rst_nops", n_ops, 0);
    check("rst_listo", listo, 0);
    check("rst_ready", dato_ready, 0);
    check("rst_zero", zero, 1);
    check("rst_sticky", cout_sticky, 0);

    // fin in IDLE is ignored and no operand is taken
    step(0, 1, 1, 4'd3);
    check("idle_ready", dato_ready, 0);
    step(0, 0, 0, 0);
    check("idle_fin_listo", listo, 0);
    check("idle_acc", acc, 0);

    // 3 + 5 + 2
    step(1, 0, 0, 0);
    step(0, 0, 1, 4'd3);
    check("t2_ready", dato_ready, 1);
    step(0, 0, 1, 4'd5);
    check("t2_lat1", acc, 3);
    step(0, 0, 1, 4'd2);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    check("t2_acc", acc, 10);
    check("t2_nops", n_ops, 3);
    check("t2_sticky", cout_sticky, 0);
    check("t2_zero", zero, 0);
    check("t2_listo", listo, 1);
    check("t2_done_ready", dato_ready, 0);
    step(0, 1, 1, 4'd1);
    step(0, 0, 0, 0);
    check("t2_done_hold", acc, 10);

    // 9 + 9 overflows
    step(1, 0, 0, 0);
    step(0, 0, 1, 4'd9);
    step(0, 0, 1, 4'd9);
    step(0, 0, 0, 0);
`ifdef SATURACION_EN
    check("t3_acc", acc, 15);
`else
    check("t3_acc", acc, 2);
`endif
    check("t3_sticky", cout_sticky, 1);
    check("t3_listo", listo, 0);

    // counter fills at 15 operands
    step(1, 0, 0, 0);
    for (int i = 0; i < 15; i++) step(0, 0, 1, 4'd1);
    step(0, 0, 1, 4'd1);
    check("t4_full_ready", dato_ready, 0);
    check("t4_acc", acc, 15);
    check("t4_nops", n_ops, 15);
    step(0, 0, 0, 0);
    check("t4_acc_hold", acc, 15);
    check("t4_nops_hold", n_ops, 15);
    check("t4_sticky", cout_sticky, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    check("t4_fin_listo", listo, 1);

    // inicio beats a simultaneous operand
    step(1, 0, 0, 0);
    step(0, 0, 1, 4'd7);
    step(1, 0, 1, 4'd4);
    check("t5_acc_before", acc, 7);
    check("t5_ready", dato_ready, 0);
    step(0, 0, 0, 0);
    check("t5_acc", acc, 0);
    check("t5_nops", n_ops, 0);
    step(0, 0, 0, 0);
    check("t5_acc_dropped", acc, 0);

    // operand together with fin is accumulated
    step(0, 0, 1, 4'd5);
    step(0, 1, 1, 4'd4);
    check("t6_acc_before", acc, 5);
    step(0, 0, 0, 0);
    check("t6_acc", acc, 9);
    check("t6_nops", n_ops, 2);
    check("t6_listo", listo, 1);

    // asynchronous reset mid-run
    step(1, 0, 0, 0);
    step(0, 0, 1, 4'd6);
    step(0, 0, 0, 0);
    check("t1_acc_before", acc, 6);
    #2 rst = 1'b1;
    #1;
    check("t1_acc", acc, 0);
    check("t1_nops", n_ops, 0);
    check("t1_listo", listo, 0);
    check("t1_ready", dato_ready, 0);
    check("t1_zero", zero, 1);
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 1, 4'd2);
    check("t1_idle_ready", dato_ready, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
